// File: rtl/sample_frame_sequencer_if.sv
// rtl/sample_frame_sequencer_if.sv - sample/result bundle between the sequencer and its environment
// Signals:
//   enable, sampling_cycle, lag_sel              control into the sequencer
//   in_sample, in_valid, in_ready                incoming audio sample stream
//   sig16b, sig16b_lag, sampling_cycle_counter   per-period drive to the canceller
//   sig16b_without_echo                          canceller result
//   out_sample, out_valid, out_ready             captured result stream
//   frame_count, underrun, overrun               status
// Modports: master = environment side, slave = sequencer side.
interface sample_frame_sequencer_if #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 13,
  parameter int LAG_AW   = 6
);
  logic                enable;
  logic [CNT_W-1:0]    sampling_cycle;
  logic [LAG_AW-1:0]   lag_sel;
  logic [SAMPLE_W-1:0] in_sample;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] sig16b;
  logic [SAMPLE_W-1:0] sig16b_lag;
  logic [CNT_W-1:0]    sampling_cycle_counter;
  logic [SAMPLE_W-1:0] sig16b_without_echo;
  logic [SAMPLE_W-1:0] out_sample;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    frame_count;
  logic                underrun;
  logic                overrun;

  modport master (
    output enable, sampling_cycle, lag_sel, in_sample, in_valid,
           sig16b_without_echo, out_ready,
    input  in_ready, sig16b, sig16b_lag, sampling_cycle_counter,
           out_sample, out_valid, frame_count, underrun, overrun
  );

  modport slave (
    input  enable, sampling_cycle, lag_sel, in_sample, in_valid,
           sig16b_without_echo, out_ready,
    output in_ready, sig16b, sig16b_lag, sampling_cycle_counter,
           out_sample, out_valid, frame_count, underrun, overrun
  );
endinterface

// File: rtl/sample_frame_sequencer.sv
// rtl/sample_frame_sequencer.sv - per-sample launch/capture sequencer for the echo canceller
// Ports:
//   clk_operation  operation clock
//   rst_n          asynchronous reset, active low
//   bus (slave)    control (enable, sampling_cycle, lag_sel), input sample stream with
//                  a small FIFO, canceller drive (sig16b, sig16b_lag, counter),
//                  canceller result, result stream and status (frame_count, sticky flags)
module sample_frame_sequencer #(
  parameter int SAMPLE_W   = 16,
  parameter int CNT_W      = 13,
  parameter int MIN_CYCLE  = 1200,
  parameter int CAPTURE_AT = 1100,
  parameter int LAG_DEPTH  = 64,
  parameter int LAG_AW     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input logic                     clk_operation,
  input logic                     rst_n,
  sample_frame_sequencer_if.slave bus
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]   CNT_IDLE  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MIN_P     = CNT_W'(MIN_CYCLE);
  localparam logic [CNT_W-1:0]   CAP_V     = CNT_W'(CAPTURE_AT);
  localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   FIFO_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] FPTR_ONE  = FIFO_AW'(1);
  localparam logic [LAG_AW:0]    LAG_FULL  = (LAG_AW+1)'(LAG_DEPTH);
  localparam logic [LAG_AW:0]    LAG_ONE   = (LAG_AW+1)'(1);
  localparam logic [LAG_AW-1:0]  LPTR_ONE  = LAG_AW'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    period;
  logic [CNT_W-1:0]    frame_cnt;
  logic                launched;
  logic [SAMPLE_W-1:0] sig_q;
  logic [SAMPLE_W-1:0] sig_lag_q;
  logic [SAMPLE_W-1:0] out_sample_q;
  logic                out_valid_q;
  logic                underrun_q;
  logic                overrun_q;
  logic                in_ready_q;

  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  fifo_rp;
  logic [FIFO_AW-1:0]  fifo_wp;
  logic [FIFO_AW:0]    fifo_cnt;
  logic [FIFO_AW:0]    fifo_cnt_next;

  logic [SAMPLE_W-1:0] lag_mem [LAG_DEPTH];
  logic [LAG_AW-1:0]   lag_wp;
  logic [LAG_AW:0]     lag_fill;   // prior launches, saturating at LAG_DEPTH
  logic [LAG_AW-1:0]   lag_rd_addr;

  logic                launch;
  logic                capture;
  logic                push;
  logic                pop;
  logic [SAMPLE_W-1:0] launch_sample;
  logic [SAMPLE_W-1:0] lag_next;
  logic [CNT_W-1:0]    next_period;

  // Launch from IDLE on the first enabled edge, otherwise at the end of the period.
  assign launch  = bus.enable && ((state == IDLE) || (cnt == period - CNT_ONE));
  assign capture = (state == RUN) && launched && (cnt == CAP_V);

  // in_ready_q mirrors !full; registering it keeps it low through reset.
  assign push = bus.in_valid && in_ready_q;
  assign pop  = launch && (fifo_cnt != '0);

  assign launch_sample = pop ? fifo_mem[fifo_rp] : '0;
  assign next_period   = (bus.sampling_cycle < MIN_P) ? MIN_P : bus.sampling_cycle;
  assign lag_rd_addr   = lag_wp - bus.lag_sel;

  always_comb begin
    lag_next = lag_mem[lag_rd_addr];
    if (bus.lag_sel == '0) begin
      lag_next = launch_sample;
    end else if ({1'b0, bus.lag_sel} > lag_fill) begin
      // Not enough history yet; the lag memory is never cleared, so mask it.
      lag_next = '0;
    end
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt + FIFO_ONE;
    end else if (pop && !push) begin
      fifo_cnt_next = fifo_cnt - FIFO_ONE;
    end
  end

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= CNT_IDLE;
      period       <= MIN_P;
      frame_cnt    <= '0;
      launched     <= 1'b0;
      sig_q        <= '0;
      sig_lag_q    <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      fifo_rp      <= '0;
      fifo_wp      <= '0;
      fifo_cnt     <= '0;
      lag_wp       <= '0;
      lag_fill     <= '0;
    end else begin
      if (launch) begin
        state     <= RUN;
        cnt       <= '0;
        period    <= next_period;
        frame_cnt <= frame_cnt + CNT_ONE;
        launched  <= 1'b1;
        sig_q     <= launch_sample;
        sig_lag_q <= lag_next;
        lag_wp    <= lag_wp + LPTR_ONE;
        if (lag_fill != LAG_FULL) begin
          lag_fill <= lag_fill + LAG_ONE;
        end
        if (!pop) begin
          underrun_q <= 1'b1;
        end
      end else if (state == RUN) begin
        if (!bus.enable) begin
          state <= IDLE;
          cnt   <= CNT_IDLE;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end

      // A capture while the previous result is still unconsumed drops the new one.
      if (capture) begin
        if (!out_valid_q || bus.out_ready) begin
          out_sample_q <= bus.sig16b_without_echo;
          out_valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (push) begin
        fifo_wp <= fifo_wp + FPTR_ONE;
      end
      if (pop) begin
        fifo_rp <= fifo_rp + FPTR_ONE;
      end
      fifo_cnt   <= fifo_cnt_next;
      in_ready_q <= (fifo_cnt_next != FIFO_FULL);
    end
  end

  // Storage arrays carry no reset; occupancy and fill counts qualify every read.
  always_ff @(posedge clk_operation) begin
    if (push) begin
      fifo_mem[fifo_wp] <= bus.in_sample;
    end
    if (launch) begin
      lag_mem[lag_wp] <= launch_sample;
    end
  end

  assign bus.in_ready               = in_ready_q;
  assign bus.sig16b                 = sig_q;
  assign bus.sig16b_lag             = sig_lag_q;
  assign bus.sampling_cycle_counter = cnt;
  assign bus.out_sample             = out_sample_q;
  assign bus.out_valid              = out_valid_q;
  assign bus.frame_count            = frame_cnt;
  assign bus.underrun               = underrun_q;
  assign bus.overrun                = overrun_q;

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// tb/tb_sample_frame_sequencer.sv - self-checking bench for sample_frame_sequencer
module tb_sample_frame_sequencer;
  localparam int MIN_CYCLE  = 1200;
  localparam int CAPTURE_AT = 1100;

  logic clk_operation = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_operation = ~clk_operation;

  sample_frame_sequencer_if #(.SAMPLE_W(16), .CNT_W(13), .LAG_AW(6)) sfs ();

  sample_frame_sequencer dut (
    .clk_operation(clk_operation),
    .rst_n        (rst_n),
    .bus          (sfs)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sample queue, launch history and result-register state.
  logic [15:0] fifo_q[$];
  logic [15:0] hist[$];
  logic        m_launch;
  logic [15:0] m_sig, m_lag, m_os;
  logic        m_ov, m_over, m_under;
  int          m_frames, m_period, m_peak;

  function automatic void model_reset();
    fifo_q.delete();
    hist.delete();
    m_launch = 1'b0;
    m_sig = '0; m_lag = '0; m_os = '0;
    m_ov = 1'b0; m_over = 1'b0; m_under = 1'b0;
    m_frames = 0; m_period = MIN_CYCLE; m_peak = 0;
  endfunction

  // One clock: sample the inputs that the coming edge acts on, then update the model.
  task automatic step();
    logic        do_push, cap, rdy;
    logic [15:0] pv, cv;
    int          lsel, sc, c;
    do_push = sfs.in_valid && sfs.in_ready;
    pv      = sfs.in_sample;
    cap     = (int'(sfs.sampling_cycle_counter) == CAPTURE_AT);
    cv      = sfs.sig16b_without_echo;
    rdy     = sfs.out_ready;
    lsel    = int'(sfs.lag_sel);
    sc      = int'(sfs.sampling_cycle);
    @(posedge clk_operation);
    #1;
    c = int'(sfs.sampling_cycle_counter);
    m_launch = (c == 0);
    if (m_launch) begin
      if (fifo_q.size() > 0) m_sig = fifo_q.pop_front();
      else begin m_sig = '0; m_under = 1'b1; end
      if (lsel == 0) m_lag = m_sig;
      else if (lsel > hist.size()) m_lag = '0;
      else m_lag = hist[hist.size() - lsel];
      hist.push_back(m_sig);
      m_frames = (m_frames + 1) % 8192;
      m_period = (sc > MIN_CYCLE) ? sc : MIN_CYCLE;
    end else if (c != 8191 && c > m_peak) begin
      m_peak = c;
    end
    if (do_push) fifo_q.push_back(pv);
    if (cap) begin
      if (!m_ov || rdy) begin m_ov = 1'b1; m_os = cv; end
      else m_over = 1'b1;
    end else if (m_ov && rdy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic wait_launch(input int budget, output int took);
    took = 0;
    do begin step(); took++; end while (!m_launch && took < budget);
    if (!m_launch) took = -1;
  endtask

  task automatic wait_count(input int value, input int budget, output bit ok);
    int n = 0;
    while (int'(sfs.sampling_cycle_counter) != value && n < budget) begin step(); n++; end
    ok = (int'(sfs.sampling_cycle_counter) == value);
  endtask

  task automatic test_reset();
    #23;
    checks++; if (sfs.sampling_cycle_counter !== 13'h1fff) begin errors++; $display("FAIL reset_counter got=%h exp=1fff", sfs.sampling_cycle_counter); end
    checks++; if (sfs.sig16b !== 16'h0) begin errors++; $display("FAIL reset_sig16b got=%h exp=0", sfs.sig16b); end
    checks++; if (sfs.sig16b_lag !== 16'h0) begin errors++; $display("FAIL reset_sig16b_lag got=%h exp=0", sfs.sig16b_lag); end
    checks++; if (sfs.out_sample !== 16'h0) begin errors++; $display("FAIL reset_out_sample got=%h exp=0", sfs.out_sample); end
    checks++; if (sfs.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", sfs.out_valid); end
    checks++; if (sfs.frame_count !== 13'h0) begin errors++; $display("FAIL reset_frame_count got=%h exp=0", sfs.frame_count); end
    checks++; if (sfs.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", sfs.underrun); end
    checks++; if (sfs.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", sfs.overrun); end
    checks++; if (sfs.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", sfs.in_ready); end
    @(posedge clk_operation);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    checks++; if (sfs.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", sfs.in_ready); end
  endtask

  task automatic test_launch_lag();
    int took;
    sfs.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sfs.in_valid  = 1'b1;
      sfs.in_sample = 16'((i + 1) * 256);
      step();
    end
    sfs.in_valid = 1'b0;
    for (int i = 0; i < 1150; i++) begin
      sfs.sig16b_without_echo = 16'($urandom);
      step();
    end
    checks++; if (sfs.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_capture got=%b exp=0", sfs.out_valid); end
    checks++; if (sfs.sampling_cycle_counter !== 13'h1fff) begin errors++; $display("FAIL idle_counter got=%h exp=1fff", sfs.sampling_cycle_counter); end
    sfs.sampling_cycle = 13'd1500;
    sfs.lag_sel = 6'd1;
    sfs.enable = 1'b1;
    wait_launch(4, took);
    checks++; if (took != 1) begin errors++; $display("FAIL first_launch_latency got=%0d exp=1", took); end
    checks++; if (sfs.sig16b !== 16'h0100 || sfs.sig16b_lag !== 16'h0000) begin errors++; $display("FAIL launch1 got=%h/%h exp=0100/0000", sfs.sig16b, sfs.sig16b_lag); end
    wait_launch(1600, took);
    checks++; if (took != 1500) begin errors++; $display("FAIL launch2_interval got=%0d exp=1500", took); end
    checks++; if (sfs.sig16b !== 16'h0200 || sfs.sig16b_lag !== 16'h0100) begin errors++; $display("FAIL launch2 got=%h/%h exp=0200/0100", sfs.sig16b, sfs.sig16b_lag); end
    wait_launch(1600, took);
    checks++; if (took != 1500) begin errors++; $display("FAIL launch3_interval got=%0d exp=1500", took); end
    checks++; if (sfs.sig16b !== 16'h0300 || sfs.sig16b_lag !== 16'h0200) begin errors++; $display("FAIL launch3 got=%h/%h exp=0300/0200", sfs.sig16b, sfs.sig16b_lag); end
    checks++; if (sfs.frame_count !== 13'd3) begin errors++; $display("FAIL frame_count3 got=%0d exp=3", sfs.frame_count); end
  endtask

  task automatic test_period_underrun();
    int took, r;
    sfs.sampling_cycle = 13'd500;
    wait_launch(1600, took);
    checks++; if (took != 1500) begin errors++; $display("FAIL period_latched got=%0d exp=1500", took); end
    checks++; if (sfs.sig16b !== 16'h0 || sfs.underrun !== 1'b1) begin errors++; $display("FAIL underrun got=%h/%b exp=0000/1", sfs.sig16b, sfs.underrun); end
    checks++; if (sfs.sig16b_lag !== 16'h0300) begin errors++; $display("FAIL underrun_lag got=%h exp=0300", sfs.sig16b_lag); end
    m_peak = 0;
    wait_launch(1300, took);
    checks++; if (took != MIN_CYCLE) begin errors++; $display("FAIL min_period got=%0d exp=%0d", took, MIN_CYCLE); end
    checks++; if (m_peak != MIN_CYCLE - 1) begin errors++; $display("FAIL counter_peak got=%0d exp=%0d", m_peak, MIN_CYCLE - 1); end
    r = $urandom_range(1201, 1260);
    sfs.sampling_cycle = 13'(r);
    wait_launch(1300, took);
    checks++; if (took != MIN_CYCLE) begin errors++; $display("FAIL period_before_change got=%0d exp=%0d", took, MIN_CYCLE); end
    wait_launch(1300, took);
    checks++; if (took != r) begin errors++; $display("FAIL period_random got=%0d exp=%0d", took, r); end
  endtask

  task automatic test_capture();
    bit ok;
    sfs.out_ready = 1'b1;
    sfs.sig16b_without_echo = 16'h1234;
    wait_count(CAPTURE_AT, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL capture_reach got=%0d exp=%0d", sfs.sampling_cycle_counter, CAPTURE_AT); end
    checks++; if (sfs.out_valid !== 1'b0) begin errors++; $display("FAIL capture_pre_valid got=%b exp=0", sfs.out_valid); end
    step();
    checks++; if (sfs.out_valid !== 1'b1 || sfs.out_sample !== 16'h1234) begin errors++; $display("FAIL capture got=%b/%h exp=1/1234", sfs.out_valid, sfs.out_sample); end
    step();
    checks++; if (sfs.out_valid !== 1'b0) begin errors++; $display("FAIL capture_consumed got=%b exp=0", sfs.out_valid); end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [15:0] a;
    a = 16'($urandom);
    sfs.out_ready = 1'b0;
    sfs.sig16b_without_echo = a;
    wait_count(CAPTURE_AT, 1500, ok);
    step();
    checks++; if (sfs.out_valid !== 1'b1 || sfs.out_sample !== a || sfs.overrun !== 1'b0) begin errors++; $display("FAIL overrun_first got=%b/%h/%b exp=1/%h/0", sfs.out_valid, sfs.out_sample, sfs.overrun, a); end
    sfs.sig16b_without_echo = a ^ 16'h5a5a;
    wait_count(CAPTURE_AT, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_reach got=%0d exp=%0d", sfs.sampling_cycle_counter, CAPTURE_AT); end
    step();
    checks++; if (sfs.out_sample !== a || sfs.overrun !== 1'b1 || sfs.out_valid !== 1'b1) begin errors++; $display("FAIL overrun_drop got=%h/%b exp=%h/1", sfs.out_sample, sfs.overrun, a); end
    sfs.out_ready = 1'b1;
    step();
    checks++; if (sfs.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain got=%b exp=0", sfs.out_valid); end
  endtask

  task automatic test_fifo_full();
    int took;
    bit ok;
    logic [15:0] first;
    wait_launch(1500, took);
    first = 16'($urandom);
    sfs.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sfs.in_sample = (i == 0) ? first : 16'($urandom);
      step();
    end
    sfs.in_sample = 16'($urandom);
    checks++; if (sfs.in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got=%b exp=0", sfs.in_ready); end
    wait_count(m_period - 1, 1500, ok);
    checks++; if (!ok || sfs.in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_hold got=%b exp=0", sfs.in_ready); end
    step();
    checks++; if (!m_launch || sfs.sig16b !== first) begin errors++; $display("FAIL fifo_pop got=%h exp=%h", sfs.sig16b, first); end
    checks++; if (sfs.in_ready !== 1'b1) begin errors++; $display("FAIL fifo_ready_rise got=%b exp=1", sfs.in_ready); end
    sfs.in_valid = 1'b0;
  endtask

  task automatic test_random_lag();
    int launches = 0, since = 0, exp_p;
    #3;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_operation);
    #3;
    rst_n = 1'b1;
    sfs.enable = 1'b1;
    while (launches < 12 && since < 2000) begin
      sfs.in_valid = ($urandom_range(0, 999) == 0);
      sfs.in_sample = 16'($urandom);
      sfs.lag_sel = 6'($urandom_range(0, 15));
      sfs.sampling_cycle = 13'($urandom_range(1100, 1300));
      sfs.out_ready = ($urandom_range(0, 3) != 0);
      sfs.sig16b_without_echo = 16'($urandom);
      exp_p = m_period;
      step();
      since++;
      checks++; if (sfs.out_valid !== m_ov || sfs.out_sample !== m_os || sfs.overrun !== m_over) begin errors++; $display("FAIL rand_out got=%b/%h/%b exp=%b/%h/%b", sfs.out_valid, sfs.out_sample, sfs.overrun, m_ov, m_os, m_over); end
      if (m_launch) begin
        checks++; if (sfs.sig16b !== m_sig || sfs.sig16b_lag !== m_lag) begin errors++; $display("FAIL rand_launch got=%h/%h exp=%h/%h", sfs.sig16b, sfs.sig16b_lag, m_sig, m_lag); end
        checks++; if (sfs.frame_count !== 13'(m_frames) || sfs.underrun !== m_under) begin errors++; $display("FAIL rand_status got=%0d/%b exp=%0d/%b", sfs.frame_count, sfs.underrun, m_frames, m_under); end
        if (launches > 0) begin
          checks++; if (since != exp_p) begin errors++; $display("FAIL rand_period got=%0d exp=%0d", since, exp_p); end
        end
        launches++;
        since = 0;
      end
    end
    checks++; if (launches != 12) begin errors++; $display("FAIL rand_launch_count got=%0d exp=12", launches); end
    sfs.in_valid = 1'b0;
  endtask

  task automatic test_disable_reset();
    bit ok;
    logic [12:0] fc;
    sfs.sampling_cycle = 13'd1300;
    sfs.out_ready = 1'b1;
    wait_count(600, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL disable_reach got=%0d exp=600", sfs.sampling_cycle_counter); end
    sfs.enable = 1'b0;
    step();
    checks++; if (sfs.sampling_cycle_counter !== 13'h1fff) begin errors++; $display("FAIL disable_counter got=%h exp=1fff", sfs.sampling_cycle_counter); end
    fc = sfs.frame_count;
    sfs.out_ready = 1'b0;
    repeat (700) step();
    checks++; if (sfs.out_valid !== 1'b0 || sfs.frame_count !== 13'(m_frames)) begin errors++; $display("FAIL disable_no_capture got=%b/%0d exp=0/%0d", sfs.out_valid, sfs.frame_count, m_frames); end
    sfs.enable = 1'b1;
    wait_count(300, 1500, ok);
    checks++; if (!ok || sfs.frame_count !== fc + 13'd1) begin errors++; $display("FAIL reenable got=%0d exp=%0d", sfs.frame_count, fc + 13'd1); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (sfs.sampling_cycle_counter !== 13'h1fff || sfs.frame_count !== 13'h0) begin errors++; $display("FAIL async_reset_cnt got=%h/%h exp=1fff/0000", sfs.sampling_cycle_counter, sfs.frame_count); end
    checks++; if (sfs.sig16b !== 16'h0 || sfs.sig16b_lag !== 16'h0 || sfs.out_sample !== 16'h0) begin errors++; $display("FAIL async_reset_data got=%h/%h/%h exp=0/0/0", sfs.sig16b, sfs.sig16b_lag, sfs.out_sample); end
    checks++; if (sfs.out_valid !== 1'b0 || sfs.underrun !== 1'b0 || sfs.overrun !== 1'b0 || sfs.in_ready !== 1'b0) begin errors++; $display("FAIL async_reset_flags got=%b%b%b%b exp=0000", sfs.out_valid, sfs.underrun, sfs.overrun, sfs.in_ready); end
    sfs.enable = 1'b0;
    repeat (3) @(posedge clk_operation);
    #1;
    checks++; if (sfs.sampling_cycle_counter !== 13'h1fff || sfs.out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold got=%h/%b exp=1fff/0", sfs.sampling_cycle_counter, sfs.out_valid); end
  endtask

  initial begin
    sfs.enable = 1'b0;
    sfs.sampling_cycle = 13'd0;
    sfs.lag_sel = 6'd0;
    sfs.in_sample = 16'h0;
    sfs.in_valid = 1'b0;
    sfs.sig16b_without_echo = 16'h0;
    sfs.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_launch_lag();
    test_period_underrun();
    test_capture();
    test_overrun();
    test_fifo_full();
    test_random_lag();
    test_disable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_frame_sequencer.md
Name: sample_frame_sequencer

Overview:
- Drives the per-sample interface of the echo-cancellation datapath: generates sampling_cycle_counter and presents a near-end sample (sig16b) plus a lagged copy (sig16b_lag) that stay stable for one sampling period.
- Captures the cancelled result (sig16b_without_echo) near the end of each period and returns it on a valid/ready stream.
- Sits between the audio sample stream and the canceller; it is the producer/consumer end of the canceller's sample interface.

Parameters:
- SAMPLE_W, 16, sample width.
- CNT_W, 13, sampling counter width.
- MIN_CYCLE, 1200, minimum legal sampling period in clocks.
- CAPTURE_AT, 1100, counter value at which the result is captured.
- LAG_DEPTH, 64, lag line entries (power of 2).
- LAG_AW, 6, log2(LAG_DEPTH).
- FIFO_DEPTH, 4, input FIFO entries (power of 2).

Ports:
- clk_operation  in  1  operation clock.
- rst_n  in  1  asynchronous reset, active low.
- enable  in  1  run sequencer.
- sampling_cycle  in  CNT_W  requested period in clocks.
- lag_sel  in  LAG_AW  lag in samples between sig16b and sig16b_lag.
- in_sample  in  SAMPLE_W  incoming audio sample.
- in_valid  in  1  in_sample valid.
- in_ready  out  1  FIFO can accept.
- sig16b  out  SAMPLE_W  current sample to canceller.
- sig16b_lag  out  SAMPLE_W  lagged sample to canceller.
- sampling_cycle_counter  out  CNT_W  period phase.
- sig16b_without_echo  in  SAMPLE_W  canceller result.
- out_sample  out  SAMPLE_W  captured result.
- out_valid  out  1  out_sample valid.
- out_ready  in  1  downstream accepts.
- frame_count  out  CNT_W  number of launches, wraps modulo 2^CNT_W.
- underrun  out  1  sticky: launch with empty FIFO.
- overrun  out  1  sticky: capture while out_valid still pending.

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE; sampling_cycle_counter = all ones (8191).
- sig16b, sig16b_lag, out_sample, frame_count = 0.
- out_valid, underrun, overrun = 0; in_ready = 0 while rst_n is low.
- FIFO empty; lag fill count = 0; launched flag = 0.

States:
- IDLE: counter held at all ones, which is never 0 and so never triggers the canceller.
  - enable = 1 → next edge is a launch: counter = 0, state RUN.
- RUN: counter increments each clock.
  - counter == P-1 and enable = 1 → next edge is a launch (counter = 0).
  - enable = 0 in any RUN cycle → next edge IDLE (counter all ones). Any pending capture is abandoned; FIFO, lag history and the output register are retained.

Period:
- P = max(sampling_cycle, MIN_CYCLE), latched at each launch.
- Changes to sampling_cycle mid-period take effect at the next launch.

Launch edge (counter becomes 0):
- sig16b, sig16b_lag and the counter update on the same edge; they are stable for the whole period.
- FIFO non-empty: pop the head, which becomes sig16b. FIFO empty: sig16b = 0 and underrun set.
- New sig16b is written into the lag line at wp, then wp increments (wraps at LAG_DEPTH).
- lag_sel is latched at each launch. sig16b_lag = sample launched lag_sel launches earlier.
  - lag_sel = 0: sig16b_lag equals the new sig16b (bypass).
  - lag_sel > number of prior launches (tracked by a fill count saturating at LAG_DEPTH): sig16b_lag = 0. The lag memory itself is not reset.
- frame_count increments; launched flag set.

Capture:
- At counter == CAPTURE_AT in RUN with launched = 1, sample sig16b_without_echo.
- CAPTURE_AT < MIN_CYCLE guarantees exactly one capture per period.
- If out_valid = 0, or out_valid = 1 with out_ready = 1 in the same cycle: out_sample = captured value, out_valid = 1.
- Otherwise keep the old out_sample and set overrun (the new result is dropped).
- out_valid clears on a cycle with out_valid & out_ready and no simultaneous capture.

Input FIFO:
- in_ready = !full; a push occurs on in_valid & in_ready.
- Push and pop on the same edge are both allowed; a push to an empty FIFO is poppable at the next launch, not the same edge.
- Full at a launch: the pop frees a slot; in_ready rises the next cycle.

Sticky flags:
- underrun and overrun clear only on reset.

Test Plan:
- Push 3 samples (0x0100, 0x0200, 0x0300), sampling_cycle = 1500, lag_sel = 1, enable → launches 1500 clocks apart; sig16b = 0x0100 / 0x0200 / 0x0300; sig16b_lag = 0 / 0x0100 / 0x0200; frame_count = 3.
- sampling_cycle = 500 → consecutive counter == 0 edges 1200 clocks apart; counter peaks at 1199.
- Drive sig16b_without_echo = 0x1234 with out_ready = 1 → out_valid rises the edge after counter == 1100, out_sample = 0x1234; no capture in the period before the first launch.
- Hold out_ready = 0 for two periods → out_sample keeps the first result and overrun = 1.
- Empty FIFO at launch → sig16b = 0, underrun = 1. Fill 4 entries → in_ready = 0; it rises the cycle after the next launch.
- Drop enable at counter = 600, then assert rst_n low mid-period → counter = 8191 and no capture fires. During reset all outputs return to reset values immediately, without waiting for a clock edge.
